datapath_p2: RTL

Parametrised two-stage successor to the 8-bit RISC datapath. Executes one register/immediate ALU operation per cycle, registers the result in an execute/writeback (EX/WB) stage and bypasses it to the next instruction's operands. Replaces the single interrupt-flag latch with an interrupt-vector FIFO. Sits between the control unit (decoded select and address fields) and the memory/COM buses of the CPU top.

---
 rtl/alu_pkg.sv | 15 +
 rtl/risc8_pkg.sv | 22 ++
 rtl/alu.sv | 66 ++++++
 rtl/irq_fifo.sv | 51 +++++
 rtl/datapath_p2.sv | 125 ++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation encoding shared by the datapath and its ALU
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_MUL = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } e_alu_op;

endpackage

// File: rtl/risc8_pkg.sv
// rtl/risc8_pkg.sv - operand-B and writeback source select codes of the datapath
package risc8_pkg;

  typedef enum logic [1:0] {
    SB_REG = 2'd0,
    SB_0   = 2'd1,
    SB_1   = 2'd2,
    SB_IMM = 2'd3
  } e_selb;

  // Code 3'd7 is unassigned and falls back to the ALU low result.
  typedef enum logic [2:0] {
    SR_MEML = 3'd0,
    SR_MEMH = 3'd1,
    SR_ALUL = 3'd2,
    SR_ALUH = 3'd3,
    SR_IMM  = 3'd4,
    SR_COM  = 3'd5,
    SR_INTR = 3'd6
  } e_selr;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational WORD-bit ALU with double-width result and compare flags
// Ports: a, b (operands), op (e_alu_op), sign (signed compare/arithmetic),
//        lo/hi (low/high result word), comp ({eq, gt, zero}).
// hi: carry/borrow bit for ADD/SUB, upper product word for MUL, else 0.
module alu
  import alu_pkg::*;
#(
  parameter int WORD = 8
) (
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  input  e_alu_op         op,
  input  logic            sign,
  output logic [WORD-1:0] lo,
  output logic [WORD-1:0] hi,
  output logic [2:0]      comp
);

  localparam int SH = $clog2(WORD);

  logic [WORD:0]            ext_a, ext_b, sum, diff;
  logic [2*WORD-1:0]        wide_a, wide_b, prod;
  logic signed [WORD-1:0]   sa, sb;
  logic                     gt;
  logic [SH-1:0]            shamt;

  // Sign-extend only when signed arithmetic is requested so one adder and
  // one multiplier cover both interpretations.
  assign ext_a  = {sign & a[WORD-1], a};
  assign ext_b  = {sign & b[WORD-1], b};
  assign sum    = ext_a + ext_b;
  assign diff   = ext_a - ext_b;
  assign wide_a = {{WORD{sign & a[WORD-1]}}, a};
  assign wide_b = {{WORD{sign & b[WORD-1]}}, b};
  assign prod   = wide_a * wide_b;
  assign sa     = a;
  assign sb     = b;
  assign shamt  = b[SH-1:0];

  always_comb begin
    gt = (a > b);
    if (sign) gt = (sa > sb);
  end

  always_comb begin
    lo = '0;
    hi = '0;
    case (op)
      ALU_ADD: begin lo = sum[WORD-1:0];  hi = {{(WORD-1){1'b0}}, sum[WORD]};  end
      ALU_SUB: begin lo = diff[WORD-1:0]; hi = {{(WORD-1){1'b0}}, diff[WORD]}; end
      ALU_AND: lo = a & b;
      ALU_OR:  lo = a | b;
      ALU_XOR: lo = a ^ b;
      ALU_MUL: {hi, lo} = prod;
      ALU_SHL: lo = a << shamt;
      ALU_SHR: begin
        if (sign) lo = sa >>> shamt;
        else      lo = a >> shamt;
      end
      default: lo = '0;
    endcase
  end

  assign comp = {a == b, gt, lo == '0};

endmodule

// File: rtl/irq_fifo.sv
// rtl/irq_fifo.sv - interrupt-vector FIFO with sticky overflow flag
// Ports: clk, rst_n (async active-low), push/din (enqueue vector), pop (dequeue head),
//        head (oldest vector, 0 when empty), empty, full, overflow (sticky drop flag).
module irq_fifo #(
  parameter int WORD  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [WORD-1:0] din,
  output logic [WORD-1:0] head,
  output logic            empty,
  output logic            full,
  output logic            overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/datapath_p2.sv
// rtl/datapath_p2.sv - two-stage register/immediate datapath with EX/WB bypass and IRQ FIFO
// Ports: clk, rst_n (async active-low), stall; a1/a2/a3 register addresses, rw_en;
//        selb/selr/alu_op/sign/imm from the control unit; com_rd, interrupt, irq_pop, mem_rd;
//        alu_comp, com_wr, com_addr, mem_wr, wb_valid, irq_pending, irq_overflow.
// Build option: DATAPATH_FWD_EN enables EX/WB -> operand forwarding; without it operands
// always come from the register file.
module datapath_p2
  import alu_pkg::*;
  import risc8_pkg::*;
#(
  parameter int   WORD      = 8,
  parameter int   NREG      = 4,
  parameter int   IRQ_DEPTH = 4,
  localparam int  RA        = $clog2(NREG)
) (
  input  logic [WORD-1:0]   imm,
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [RA-1:0]     a1,
  input  logic [RA-1:0]     a2,
  input  logic [RA-1:0]     a3,
  input  logic              rw_en,
  input  logic [1:0]        selb,
  input  logic [2:0]        selr,
  input  e_alu_op           alu_op,
  input  logic              sign,
  input  logic [WORD-1:0]   com_rd,
  input  logic              interrupt,
  input  logic              irq_pop,
  input  logic [2*WORD-1:0] mem_rd,
  output logic [2:0]        alu_comp,
  output logic [WORD-1:0]   com_wr,
  output logic [WORD-1:0]   com_addr,
  output logic [2*WORD-1:0] mem_wr,
  output logic              wb_valid,
  output logic              irq_pending,
  output logic              irq_overflow
);

  logic [WORD-1:0] regs [NREG];
  logic [RA-1:0]   wb_addr;
  logic [WORD-1:0] wb_data;
  logic            wb_en;
  logic [WORD-1:0] r1, r2, srcb, alu_lo, alu_hi, wdata, irq_head;
  logic            irq_empty, irq_full;

`ifdef DATAPATH_FWD_EN
  // Bypass stays live while stalled because the pending write has not committed.
  assign r1 = (wb_en && a1 == wb_addr) ? wb_data : regs[a1];
  assign r2 = (wb_en && a2 == wb_addr) ? wb_data : regs[a2];
`else
  assign r1 = regs[a1];
  assign r2 = regs[a2];
`endif

  always_comb begin
    srcb = r2;
    case (selb)
      SB_0:    srcb = '0;
      SB_1:    srcb = {{(WORD-1){1'b0}}, 1'b1};
      SB_IMM:  srcb = imm;
      default: srcb = r2;
    endcase
  end

  alu #(.WORD(WORD)) u_alu (
    .a    (r1),
    .b    (srcb),
    .op   (alu_op),
    .sign (sign),
    .lo   (alu_lo),
    .hi   (alu_hi),
    .comp (alu_comp)
  );

  irq_fifo #(.WORD(WORD), .DEPTH(IRQ_DEPTH)) u_irq_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (interrupt),
    .pop      (irq_pop),
    .din      (com_rd),
    .head     (irq_head),
    .empty    (irq_empty),
    .full     (irq_full),
    .overflow (irq_overflow)
  );

  always_comb begin
    wdata = alu_lo;
    case (selr)
      SR_MEML: wdata = mem_rd[WORD-1:0];
      SR_MEMH: wdata = mem_rd[2*WORD-1:WORD];
      SR_ALUL: wdata = alu_lo;
      SR_ALUH: wdata = alu_hi;
      SR_IMM:  wdata = imm;
      SR_COM:  wdata = com_rd;
      SR_INTR: wdata = irq_head;
      default: wdata = alu_lo;
    endcase
  end

  // A stall freezes both the EX/WB register and the commit, so a held write
  // lands exactly once on the first unstalled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (!stall) begin
      if (wb_en) regs[wb_addr] <= wb_data;
      wb_en   <= rw_en;
      wb_addr <= a3;
      wb_data <= wdata;
    end
  end

  assign com_wr      = r1;
  assign com_addr    = imm;
  assign mem_wr      = {r2, r1};
  assign wb_valid    = wb_en;
  assign irq_pending = ~irq_empty | (irq_full & 1'b0);

endmodule
